// File: rtl/alu_status_unit.sv
// ALU result register plus NZCV status flags with condition-code evaluation.
// The result and the flags are written independently; cond_pass looks only at the stored flags.
module alu_status_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] alu_in,
   input  logic             z_in,
   input  logic             c_in,
   input  logic             n_in,
   input  logic             v_in,
   input  logic             alu_we,
   input  logic [1:0]       flag_we,
   input  logic [3:0]       cond,
   output logic [WIDTH-1:0] alu_reg,
   output logic [3:0]       flags,
   output logic             flags_valid,
   output logic             cond_pass
);

   localparam logic [1:0] FW_HOLD = 2'b00;
   localparam logic [1:0] FW_NZ   = 2'b01;
   localparam logic [1:0] FW_RSVD = 2'b10;
   localparam logic [1:0] FW_ALL  = 2'b11;

   // Stored flag bit positions inside flags = {N,Z,C,V}
   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;

   // An unknown ALU output (X/Z) is stored as 0 so it never reaches state.
   function automatic logic [WIDTH-1:0] clean_word(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = (v[i] === 1'b1);
      end
      return r;
   endfunction

   function automatic logic clean_bit(input logic v);
      return (v === 1'b1);
   endfunction

   logic n_q, z_q, c_q, v_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_reg     <= '0;
         flags       <= 4'b0000;
         flags_valid <= 1'b0;
      end else begin
         if (alu_we) begin
            alu_reg <= clean_word(alu_in);
         end
         case (flag_we)
            FW_ALL: begin
               flags[N_BIT] <= clean_bit(n_in);
               flags[Z_BIT] <= clean_bit(z_in);
               flags[C_BIT] <= clean_bit(c_in);
               flags[V_BIT] <= clean_bit(v_in);
               flags_valid  <= 1'b1;
            end
            FW_NZ: begin
               flags[N_BIT] <= clean_bit(n_in);
               flags[Z_BIT] <= clean_bit(z_in);
               flags_valid  <= 1'b1;
            end
            FW_HOLD, FW_RSVD: begin
            end
            default: begin
            end
         endcase
      end
   end

   assign n_q = flags[N_BIT];
   assign z_q = flags[Z_BIT];
   assign c_q = flags[C_BIT];
   assign v_q = flags[V_BIT];

   // Until a flag write has happened the stored flags mean nothing, so only AL passes.
   always_comb begin
      cond_pass = 1'b0;
      if (!flags_valid) begin
         cond_pass = (cond == 4'd14);
      end else begin
         case (cond)
            4'd0:  cond_pass = z_q;
            4'd1:  cond_pass = !z_q;
            4'd2:  cond_pass = c_q;
            4'd3:  cond_pass = !c_q;
            4'd4:  cond_pass = n_q;
            4'd5:  cond_pass = !n_q;
            4'd6:  cond_pass = v_q;
            4'd7:  cond_pass = !v_q;
            4'd8:  cond_pass = c_q && !z_q;
            4'd9:  cond_pass = !c_q || z_q;
            4'd10: cond_pass = (n_q == v_q);
            4'd11: cond_pass = (n_q != v_q);
            4'd12: cond_pass = !z_q && (n_q == v_q);
            4'd13: cond_pass = z_q || (n_q != v_q);
            4'd14: cond_pass = 1'b1;
            4'd15: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_status_unit.sv
// Directed bench for alu_status_unit: register/flag state checked through an expected
// queue after each clock, condition codes checked against an independent truth model.
module tb_alu_status_unit;

   localparam int WIDTH = 32;
   localparam int SW    = WIDTH + 5;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] alu_in;
   logic             z_in, c_in, n_in, v_in;
   logic             alu_we;
   logic [1:0]       flag_we;
   logic [3:0]       cond;
   logic [WIDTH-1:0] alu_reg;
   logic [3:0]       flags;
   logic             flags_valid;
   logic             cond_pass;

   int n_assert = 0;
   int n_fail   = 0;

   logic [SW-1:0] exp_q[$];

   // reference state
   logic [WIDTH-1:0] m_reg   = '0;
   logic [3:0]       m_flags = '0;
   logic             m_valid = 1'b0;

   alu_status_unit #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .alu_in(alu_in),
      .z_in(z_in), .c_in(c_in), .n_in(n_in), .v_in(v_in),
      .alu_we(alu_we), .flag_we(flag_we), .cond(cond),
      .alu_reg(alu_reg), .flags(flags), .flags_valid(flags_valid), .cond_pass(cond_pass)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Truth model written from the flag semantics rather than as a case table.
   function automatic logic cond_model(input logic [3:0] f, input logic valid, input logic [3:0] c);
      logic n, z, cy, v, base;
      if (!valid) return (c == 4'd14);
      {n, z, cy, v} = f;
      unique case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy & ~z;
         3'd5: base = ~(n ^ v);
         3'd6: base = ~z & ~(n ^ v);
         default: base = 1'b1;
      endcase
      return c[0] ? ~base : base;
   endfunction

   // Drive one cycle of stimulus and push the state expected after the edge.
   task automatic drive(input logic r, input logic we, input logic [WIDTH-1:0] d,
                        input logic [1:0] fwe, input logic [3:0] nzcv);
      rst = r; alu_we = we; alu_in = d; flag_we = fwe;
      {n_in, z_in, c_in, v_in} = nzcv;
      if (!r) begin
         m_reg = '0; m_flags = '0; m_valid = 1'b0;
      end else begin
         if (we) m_reg = d;
         if (fwe == 2'b11) begin m_flags = nzcv; m_valid = 1'b1; end
         if (fwe == 2'b01) begin m_flags[3:2] = nzcv[3:2]; m_valid = 1'b1; end
      end
      exp_q.push_back({m_reg, m_flags, m_valid});
   endtask

   task automatic tick_check(input string tag);
      logic [SW-1:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_alu_reg"}, 64'(alu_reg), 64'(e[SW-1:5]));
         chk({tag, "_flags"}, 64'(flags), 64'(e[4:1]));
         chk({tag, "_flags_valid"}, 64'(flags_valid), 64'(e[0]));
      end
      rst = 1'b1; alu_we = 1'b0; flag_we = 2'b00;
   endtask

   task automatic sweep_cond(input string tag);
      for (int c = 0; c < 16; c++) begin
         cond = 4'(c);
         #1;
         chk($sformatf("%s_cond%0d_f%b_v%b", tag, c, m_flags, m_valid),
             64'(cond_pass), 64'(cond_model(m_flags, m_valid, 4'(c))));
      end
   endtask

   initial begin
      rst = 1'b0; alu_we = 1'b0; alu_in = '0; flag_we = 2'b00; cond = 4'd0;
      {n_in, z_in, c_in, v_in} = 4'b0000;
      @(posedge clk); #1;

      // Reset dominates simultaneous writes
      drive(1'b0, 1'b1, 32'h1234_5678, 2'b11, 4'b1111);
      tick_check("reset");
      sweep_cond("after_reset");

      // Result capture only; flags stay invalid
      drive(1'b1, 1'b1, 32'hDEADBEEF, 2'b00, 4'b1111);
      tick_check("capture");
      sweep_cond("no_flags");
      drive(1'b1, 1'b0, 32'hFFFF_0000, 2'b10, 4'b1111);
      tick_check("hold_rsvd_invalid");

      // Full flag write N=1,V=1
      drive(1'b1, 1'b0, 32'h0, 2'b11, 4'b1001);
      tick_check("fw11");
      cond = 4'd10; #1; chk("ge_1001", 64'(cond_pass), 64'd1);
      cond = 4'd12; #1; chk("gt_1001", 64'(cond_pass), 64'd1);
      cond = 4'd0;  #1; chk("eq_1001", 64'(cond_pass), 64'd0);

      // N/Z only update, then reserved mode holds
      drive(1'b1, 1'b0, 32'h0, 2'b01, 4'b0111);
      tick_check("fw01");
      chk("fw01_value", 64'(flags), 64'h5);
      drive(1'b1, 1'b0, 32'h0, 2'b10, 4'b1010);
      tick_check("fw10");

      // cond_pass has no bypass from the live flag inputs
      drive(1'b1, 1'b0, 32'h0, 2'b11, 4'b0000);
      tick_check("clear_flags");
      drive(1'b1, 1'b1, 32'hA5A5_5A5A, 2'b11, 4'b0100);
      cond = 4'd0; #1;
      chk("no_bypass_same_cycle", 64'(cond_pass), 64'd0);
      tick_check("both_enables");
      cond = 4'd0; #1;
      chk("eq_next_cycle", 64'(cond_pass), 64'd1);

      // Random result captures with random enables
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'($urandom_range(0, 1)), 32'($urandom),
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
         tick_check($sformatf("rand%0d", i));
         cond = 4'($urandom_range(0, 15)); #1;
         chk($sformatf("rand%0d_cond", i), 64'(cond_pass), 64'(cond_model(m_flags, m_valid, cond)));
      end

      // Exhaustive condition decode
      for (int f = 0; f < 16; f++) begin
         drive(1'b1, 1'b0, 32'h0, 2'b11, 4'(f));
         tick_check($sformatf("sweep_f%0d", f));
         sweep_cond("sweep");
      end

      // Reset in the same cycle as both writes
      drive(1'b0, 1'b1, 32'hCAFE_F00D, 2'b11, 4'b1111);
      tick_check("reset_prio");
      sweep_cond("after_reset2");

      // First edge after reset honours enables
      drive(1'b1, 1'b1, 32'h0000_0042, 2'b01, 4'b0100);
      tick_check("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
